// File: rtl/maxpool_2x2_ctrl_if.sv
// Pixel-in / pooled-result-out stream bundle for the 2x2 max-pool block.
// slave is the pooling block; master is the surrounding producer/consumer.
interface maxpool_2x2_ctrl_if #(parameter int DATA_BITS = 8);
  logic                 in_valid;
  logic                 in_ready;
  logic [DATA_BITS-1:0] in_data;
  logic                 out_valid;
  logic                 out_ready;
  logic [DATA_BITS-1:0] out_data;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );
endinterface

// File: rtl/maxpool_2x2_ctrl.sv
// Streaming 2x2 / stride-2 signed max-pool over a row-major pixel stream.
// Even rows park horizontal pair maxima in a line buffer; odd rows finish the window.
module maxpool_2x2_ctrl #(
  parameter int DATA_BITS = 8,
  parameter int IN_W      = 28,
  parameter int IN_H      = 28
) (
  input  logic                  clk,
  input  logic                  rst,
  maxpool_2x2_ctrl_if.slave     s,
  output logic                  frame_done,
  output logic                  busy
);
  localparam int CW = (IN_W > 1) ? $clog2(IN_W) : 1;
  localparam int RW = (IN_H > 1) ? $clog2(IN_H) : 1;
  localparam int LD = IN_W / 2;
  localparam int LW = (IN_W > 2) ? $clog2(LD) : 1;

  typedef enum logic [1:0] {S_IDLE, S_EVEN, S_ODD, S_DRAIN} state_t;

  state_t                      state, nxt;
  logic [CW-1:0]               col;
  logic [RW-1:0]               row;
  logic [LW-1:0]               lidx;
  logic signed [DATA_BITS-1:0] din, hold, pmax, vmax;
  logic signed [DATA_BITS-1:0] lbuf [LD];
  logic                        acc, ohs, col_last, row_last, new_res;

  assign s.in_ready = !s.out_valid || s.out_ready;
  assign acc        = s.in_valid && s.in_ready;
  assign ohs        = s.out_valid && s.out_ready;
  assign col_last   = (col == CW'(IN_W - 1));
  assign row_last   = (row == RW'(IN_H - 1));
  assign lidx       = LW'(col >> 1);
  assign din        = $signed(s.in_data);
  assign pmax       = (hold > din) ? hold : din;
  assign vmax       = (lbuf[lidx] > pmax) ? lbuf[lidx] : pmax;
  assign new_res    = acc && col[0] && row[0];
  assign busy       = (state != S_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col <= '0;
      row <= '0;
    end else if (acc) begin
      if (col_last) begin
        col <= '0;
        row <= row_last ? '0 : row + RW'(1);
      end else begin
        col <= col + CW'(1);
      end
    end
  end

  // Pair register and line buffer need no reset: each entry is written before use.
  always_ff @(posedge clk) begin
    if (acc && !col[0]) hold <= din;
    if (acc && col[0] && !row[0]) lbuf[lidx] <= pmax;
  end

  // A new result may land in the same cycle the previous one is taken.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s.out_valid <= 1'b0;
      s.out_data  <= '0;
      frame_done  <= 1'b0;
    end else begin
      frame_done <= acc && col_last && row_last;
      if (new_res) begin
        s.out_valid <= 1'b1;
        s.out_data  <= vmax;
      end else if (ohs) begin
        s.out_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= nxt;
  end

  // In S_DRAIN out_valid is high, so any accept there coincides with the final handshake.
  always_comb begin
    nxt = state;
    case (state)
      S_IDLE:  if (acc) nxt = S_EVEN;
      S_EVEN:  if (acc && col_last) nxt = S_ODD;
      S_ODD:   if (acc && col_last) nxt = row_last ? S_DRAIN : S_EVEN;
      S_DRAIN: if (ohs) nxt = acc ? S_EVEN : S_IDLE;
      default: nxt = S_IDLE;
    endcase
  end
endmodule
